pkt_buffer_write: RTL
=====================

Name: pkt_buffer_write

Overview:
- Sits directly downstream of the receive-side frame parser.
- Accepts 134-bit packet words and the buffer ID allocated for each frame.
- Queues the words in a small FIFO, computes the packet-buffer line address {bufid, line}, and issues one write per word to the central packet-buffer arbiter using a request/ack handshake.
- Protects the buffer against overlength frames and FIFO overflow, and reports every discard.

Parameters:
- data_fifo_depth_log2, 4, log2 of the word FIFO depth (default 16 words).
- max_line, 7'd127, highest line index written per buffer; 128 lines × 16 B = 2 KB per bufid.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- iv_pkt  in  134  packet word. [133:132] = flag: 01 head, 00 middle, 10 tail, 11 head+tail. [131:128] = valid-byte count − 1. [127:0] = data.
- i_pkt_wr  in  1  iv_pkt valid
- iv_pkt_bufid  in  9  buffer ID of the frame
- i_pkt_bufid_wr  in  1  iv_pkt_bufid valid; arrives no later than the frame's head word
- ov_wr_data  out  134  word to packet buffer
- ov_wr_addr  out  16  {bufid[8:0], line[6:0]}
- o_wr_req  out  1  write request to arbiter
- i_wr_ack  in  1  arbiter accepted the current word
- o_frame_done_pulse  out  1  tail word of a frame accepted by the arbiter
- o_discard_pulse  out  1  frame truncated or dropped
- ov_write_state  out  2  FSM state, for debug

Behaviour:
- Reset: all outputs 0; FSM in IDLE; FIFOs empty; line counter 0.
- Bufid capture: a 2-entry bufid FIFO. i_pkt_bufid_wr while full → ID ignored and o_discard_pulse for 1 cycle.
- Input side, per cycle:
  - A word is pushed when i_pkt_wr=1, the input gate is open, and the data FIFO is not full.
  - Push while the FIFO is full → the word and the rest of the frame, up to and including the tail, are dropped. The gate closes until the next head. o_discard_pulse fires once per affected frame. Words already queued from that frame are still written.
  - A head word arriving while the input-side line count is nonzero (no tail seen) → treat as a new frame. The old frame is not closed; o_discard_pulse fires.
- Output FSM:
  - IDLE: if the data FIFO is non-empty and its head-of-FIFO word is a head (01/11) → go to WAIT_BUFID. If the word is not a head, pop and discard it, stay in IDLE, and pulse o_discard_pulse.
  - WAIT_BUFID: once the bufid FIFO is non-empty, pop it into the bufid register, set line=0 → go to TRANS.
  - TRANS:
    - Drive o_wr_req=1 with ov_wr_data = head-of-FIFO word and ov_wr_addr={bufid,line}.
    - On i_wr_ack: pop the FIFO and increment line.
    - If the popped word is a tail (10/11): drop o_wr_req the next cycle, pulse o_frame_done_pulse in that cycle, and go to IDLE.
    - If line==max_line and the popped word is not a tail → go to DISCARD and pulse o_discard_pulse.
    - o_wr_req stays asserted and the data/address stay stable until ack. If the FIFO is empty, o_wr_req=0.
  - DISCARD: pop words without writing until a tail is popped → IDLE.
- Latency: a head word pushed into an empty FIFO with the bufid already present gives o_wr_req 3 cycles after i_pkt_wr (push, IDLE→WAIT_BUFID, WAIT_BUFID→TRANS). Throughput is 1 word/cycle with ack held high.
- Simultaneous push and pop on the same cycle are allowed at every FIFO level, including full: when full, a pop in that cycle frees the slot, so the push is accepted.
- Reset mid-frame: all state cleared; no partial pulses.
- ov_write_state encoding: 0 IDLE, 1 WAIT_BUFID, 2 TRANS, 3 DISCARD.

Optional Feature:
- Macro PKT_BUFFER_WRITE_STAT_EN.
- When defined, add outputs:
  - ov_frame_cnt[15:0]: increments on o_frame_done_pulse.
  - ov_discard_cnt[15:0]: increments on o_discard_pulse.
  - Both reset to 0, wrap 16'hFFFF→0.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Single 64 B frame (head, 2 middle, tail; flags 01,00,00,10), bufid 9'h05 one cycle before head, ack held 1 → 4 writes at addr 16'h0280..16'h0283; o_frame_done_pulse once after the tail ack.
- Single-word frame (flag 11), bufid 9'h1FF, ack delayed 5 cycles → o_wr_req held 5 cycles with stable data and addr 16'hFF80; one write; done pulse.
- Overlength: 130-word frame, bufid 9'h01 → 128 writes at addr 0x0080–0x00FF; o_discard_pulse once; 2 words dropped; no done pulse; next frame written normally.
- FIFO overflow: ack held 0, 20-word frame pushed → 16 queued, o_discard_pulse once. After ack is released, exactly 16 words are written and the FSM goes to DISCARD→IDLE only if the tail was queued. Here the tail was dropped, so the next head must still be handled correctly via the head-check rule in IDLE.
- Bufid late: head pushed, bufid arrives 10 cycles later → FSM held in WAIT_BUFID, writes start 1 cycle after bufid capture.
- Reset asserted mid-frame at word 2 → all outputs 0 immediately; a following frame after reset writes from line 0.

Source files
------------

// File: rtl/pkt_buffer_write.sv
// pkt_buffer_write: queues parsed rx words and issues one packet-buffer write per word.
// Build macro PKT_BUFFER_WRITE_STAT_EN adds frame and discard counters.
module pkt_buffer_write #(
    parameter int unsigned data_fifo_depth_log2 = 4,
    parameter logic [6:0]  max_line             = 7'd127
) (
    input  logic         clk_sys,
    input  logic         reset_n,
    input  logic [133:0] iv_pkt,
    input  logic         i_pkt_wr,
    input  logic [8:0]   iv_pkt_bufid,
    input  logic         i_pkt_bufid_wr,
    output logic [133:0] ov_wr_data,
    output logic [15:0]  ov_wr_addr,
    output logic         o_wr_req,
    input  logic         i_wr_ack,
    output logic         o_frame_done_pulse,
    output logic         o_discard_pulse,
`ifdef PKT_BUFFER_WRITE_STAT_EN
    output logic [15:0]  ov_frame_cnt,
    output logic [15:0]  ov_discard_cnt,
`endif
    output logic [1:0]   ov_write_state
);

    localparam int unsigned DW    = data_fifo_depth_log2;
    localparam int unsigned DEPTH = 1 << DW;

    localparam logic [DW:0] FULL_CNT = {1'b1, {DW{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_BUFID = 2'd1,
        S_TRANS      = 2'd2,
        S_DISCARD    = 2'd3
    } state_e;

    state_e state_q, state_d;

    // data FIFO
    logic [133:0]  dmem_q [DEPTH];
    logic [DW-1:0] dwp_q, dwp_d;
    logic [DW-1:0] drp_q, drp_d;
    logic [DW:0]   dcnt_q, dcnt_d;
    logic          d_empty, d_full;
    logic          d_push, d_pop, d_room;

    // bufid FIFO
    logic [8:0] bmem_q [2];
    logic       bwp_q, bwp_d;
    logic       brp_q, brp_d;
    logic [1:0] bcnt_q, bcnt_d;
    logic       b_push, b_pop, b_ovf;

    // input-side frame tracking
    logic gate_q, gate_d;
    logic in_frame_q, in_frame_d;
    logic in_head, in_tail;
    logic in_ovf, in_restart;

    // write-side context
    logic [8:0] bufid_q, bufid_d;
    logic [6:0] line_q, line_d;

    logic [133:0] hd_word;
    logic         hd_head, hd_tail;
    logic         stale_head;
    logic         wr_req, wr_fire;
    logic         ev_done, ev_orphan, ev_ovl;
    logic         done_q, done_d;
    logic         disc_q, disc_d;

    assign d_empty = (dcnt_q == '0);
    assign d_full  = (dcnt_q == FULL_CNT);

    assign hd_word = dmem_q[drp_q];
    assign hd_head = hd_word[132];
    assign hd_tail = hd_word[133];

    // A head word seen mid-frame means the previous frame lost its tail.
    assign stale_head = !d_empty && hd_head && (line_q != '0);
    assign wr_fire    = wr_req && i_wr_ack;

    assign in_head = iv_pkt[132];
    assign in_tail = iv_pkt[133];

    // Input gate: a head always reopens it; a pop this cycle frees a slot.
    always_comb begin
        d_room     = !d_full || d_pop;
        d_push     = i_pkt_wr && (gate_q || in_head) && d_room;
        in_ovf     = i_pkt_wr && (gate_q || in_head) && !d_room;
        in_restart = i_pkt_wr && in_head && in_frame_q;
        gate_d     = gate_q;
        in_frame_d = in_frame_q;
        if (in_ovf) begin
            gate_d     = 1'b0;
            in_frame_d = 1'b0;
        end else if (d_push) begin
            gate_d     = 1'b1;
            in_frame_d = !in_tail;
        end
    end

    // Data FIFO pointer and occupancy update.
    always_comb begin
        dwp_d  = d_push ? dwp_q + 1'b1 : dwp_q;
        drp_d  = d_pop ? drp_q + 1'b1 : drp_q;
        dcnt_d = dcnt_q;
        if (d_push && !d_pop) begin
            dcnt_d = dcnt_q + 1'b1;
        end else if (!d_push && d_pop) begin
            dcnt_d = dcnt_q - 1'b1;
        end
    end

    // Bufid FIFO: an ID arriving while both entries are taken is dropped.
    always_comb begin
        b_push = i_pkt_bufid_wr && ((bcnt_q != 2'd2) || b_pop);
        b_ovf  = i_pkt_bufid_wr && !b_push;
        bwp_d  = b_push ? ~bwp_q : bwp_q;
        brp_d  = b_pop ? ~brp_q : brp_q;
        bcnt_d = bcnt_q;
        if (b_push && !b_pop) begin
            bcnt_d = bcnt_q + 2'd1;
        end else if (!b_push && b_pop) begin
            bcnt_d = bcnt_q - 2'd1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (!d_empty && hd_head) begin
                    state_d = S_WAIT_BUFID;
                end
            end
            S_WAIT_BUFID: begin
                if (bcnt_q != 2'd0) begin
                    state_d = S_TRANS;
                end
            end
            S_TRANS: begin
                if (stale_head) begin
                    state_d = S_IDLE;
                end else if (wr_fire) begin
                    if (hd_tail) begin
                        state_d = S_IDLE;
                    end else if (line_q == max_line) begin
                        state_d = S_DISCARD;
                    end
                end
            end
            S_DISCARD: begin
                if (!d_empty && (hd_head || hd_tail)) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // FSM outputs: request, FIFO pops and discard/done events.
    always_comb begin
        wr_req    = 1'b0;
        d_pop     = 1'b0;
        b_pop     = 1'b0;
        ev_done   = 1'b0;
        ev_orphan = 1'b0;
        ev_ovl    = 1'b0;
        bufid_d   = bufid_q;
        line_d    = line_q;
        unique case (state_q)
            S_IDLE: begin
                if (!d_empty && !hd_head) begin
                    d_pop     = 1'b1;
                    ev_orphan = 1'b1;
                end
            end
            S_WAIT_BUFID: begin
                if (bcnt_q != 2'd0) begin
                    b_pop   = 1'b1;
                    bufid_d = bmem_q[brp_q];
                    line_d  = '0;
                end
            end
            S_TRANS: begin
                wr_req = !d_empty && !stale_head;
                if (wr_req && i_wr_ack) begin
                    d_pop   = 1'b1;
                    line_d  = line_q + 7'd1;
                    ev_done = hd_tail;
                    ev_ovl  = !hd_tail && (line_q == max_line);
                end
            end
            S_DISCARD: begin
                d_pop = !d_empty && !hd_head;
            end
        endcase
    end

    assign done_d = ev_done;
    assign disc_d = ev_orphan | ev_ovl | in_ovf | in_restart | b_ovf;

    // Control registers: FIFO pointers, gate, write context and pulses.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dwp_q      <= '0;
            drp_q      <= '0;
            dcnt_q     <= '0;
            bwp_q      <= 1'b0;
            brp_q      <= 1'b0;
            bcnt_q     <= '0;
            gate_q     <= 1'b1;
            in_frame_q <= 1'b0;
            bufid_q    <= '0;
            line_q     <= '0;
            done_q     <= 1'b0;
            disc_q     <= 1'b0;
        end else begin
            dwp_q      <= dwp_d;
            drp_q      <= drp_d;
            dcnt_q     <= dcnt_d;
            bwp_q      <= bwp_d;
            brp_q      <= brp_d;
            bcnt_q     <= bcnt_d;
            gate_q     <= gate_d;
            in_frame_q <= in_frame_d;
            bufid_q    <= bufid_d;
            line_q     <= line_d;
            done_q     <= done_d;
            disc_q     <= disc_d;
        end
    end

    // FIFO storage; pointers alone define validity, so no reset.
    always_ff @(posedge clk_sys) begin
        if (d_push) begin
            dmem_q[dwp_q] <= iv_pkt;
        end
        if (b_push) begin
            bmem_q[bwp_q] <= iv_pkt_bufid;
        end
    end

    assign o_wr_req           = wr_req;
    assign ov_wr_data         = wr_req ? hd_word : '0;
    assign ov_wr_addr         = wr_req ? {bufid_q, line_q} : '0;
    assign o_frame_done_pulse = done_q;
    assign o_discard_pulse    = disc_q;
    assign ov_write_state     = state_q;

`ifdef PKT_BUFFER_WRITE_STAT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] disc_cnt_q, disc_cnt_d;

    assign frame_cnt_d = done_q ? frame_cnt_q + 16'd1 : frame_cnt_q;
    assign disc_cnt_d  = disc_q ? disc_cnt_q + 16'd1 : disc_cnt_q;

    // Free-running event counters, wrapping at 16 bits.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_q <= '0;
            disc_cnt_q  <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            disc_cnt_q  <= disc_cnt_d;
        end
    end

    assign ov_frame_cnt   = frame_cnt_q;
    assign ov_discard_cnt = disc_cnt_q;
`endif

endmodule
